// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes, condition codes and NZCV bit positions
// used by the writeback stage and anything else that decodes ALU fields.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_RSB = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_EOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_MVN = 4'b0111;
  localparam logic [3:0] OP_ADC = 4'b1000;
  localparam logic [3:0] OP_SBC = 4'b1001;
  localparam logic [3:0] OP_RSC = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1100;
  localparam logic [3:0] OP_STR = 4'b1101;
  localparam logic [3:0] OP_BRA = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [3:0] CC_AL = 4'b0000;
  localparam logic [3:0] CC_EQ = 4'b0001;
  localparam logic [3:0] CC_NE = 4'b0010;
  localparam logic [3:0] CC_CS = 4'b0011;
  localparam logic [3:0] CC_CC = 4'b0100;
  localparam logic [3:0] CC_MI = 4'b0101;
  localparam logic [3:0] CC_PL = 4'b0110;
  localparam logic [3:0] CC_VS = 4'b0111;
  localparam logic [3:0] CC_VC = 4'b1000;
  localparam logic [3:0] CC_HI = 4'b1001;
  localparam logic [3:0] CC_LS = 4'b1010;
  localparam logic [3:0] CC_GE = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GT = 4'b1101;
  localparam logic [3:0] CC_LE = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_writeback_stage_wb_fifo.sv
// Small register-file write queue with registered full/empty flags.
// Storage is not reset; head output is forced to zero while empty.
module wb_fifo #(
  parameter int WIDTH      = 36,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: owns NZCV, evaluates conditions, queues RF writes.
// Optional macro ALU_WB_SKIP_CNT_EN adds a saturating skipped-instruction counter.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op_code,
  input  logic [3:0]            conditions,
  input  logic                  s,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [3:0]            status_nzcv,
`ifdef ALU_WB_SKIP_CNT_EN
  output logic [15:0]           skip_count,
`endif
  output logic                  cond_pass
);

  localparam int ENTRY_W = DATA_W + REG_ADDR_W;

  logic                accept;
  logic                flag_upd;
  logic                push_op;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;
  logic                n_f, z_f, c_f, v_f;

  assign n_f = status_nzcv[FLAG_N];
  assign z_f = status_nzcv[FLAG_Z];
  assign c_f = status_nzcv[FLAG_C];
  assign v_f = status_nzcv[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    case (conditions)
      CC_AL:   cond_pass = 1'b1;
      CC_EQ:   cond_pass = z_f;
      CC_NE:   cond_pass = ~z_f;
      CC_CS:   cond_pass = c_f;
      CC_CC:   cond_pass = ~c_f;
      CC_MI:   cond_pass = n_f;
      CC_PL:   cond_pass = ~n_f;
      CC_VS:   cond_pass = v_f;
      CC_VC:   cond_pass = ~v_f;
      CC_HI:   cond_pass = c_f & ~z_f;
      CC_LS:   cond_pass = ~c_f | z_f;
      CC_GE:   cond_pass = (n_f == v_f);
      CC_LT:   cond_pass = (n_f != v_f);
      CC_GT:   cond_pass = ~z_f & (n_f == v_f);
      CC_LE:   cond_pass = z_f | (n_f != v_f);
      default: cond_pass = 1'b0;
    endcase
  end

  // Logic ops (ORR..MVN) leave the ALU flags stale, so they never update NZCV.
  always_comb begin
    flag_upd = 1'b0;
    case (op_code)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC, OP_RSC: flag_upd = s;
      OP_CMP:  flag_upd = 1'b1;
      default: flag_upd = 1'b0;
    endcase
  end

  assign push_op = (op_code <= OP_RSC);
  assign accept  = in_valid & in_ready;
  assign push    = accept & cond_pass & push_op;
  assign pop     = wb_valid & wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_nzcv <= 4'b0000;
    end else if (accept && cond_pass && flag_upd) begin
      status_nzcv <= alu_flags;
    end
  end

`ifdef ALU_WB_SKIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_count <= 16'h0000;
    end else if (accept && !cond_pass && skip_count != 16'hFFFF) begin
      skip_count <= skip_count + 16'd1;
    end
  end
`endif

  wb_fifo #(
    .WIDTH      (ENTRY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({dest_reg, alu_result}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign wb_valid = ~fifo_empty;
  assign wb_addr  = head[ENTRY_W-1:DATA_W];
  assign wb_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage; also covers ALU_WB_SKIP_CNT_EN when defined.
`timescale 1ns/1ps
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_code;
  logic [3:0]  conditions;
  logic        s;
  logic [3:0]  dest_reg;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  status_nzcv;
  logic        cond_pass;
`ifdef ALU_WB_SKIP_CNT_EN
  logic [15:0] skip_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_code     (op_code),
    .conditions  (conditions),
    .s           (s),
    .dest_reg    (dest_reg),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .status_nzcv (status_nzcv),
`ifdef ALU_WB_SKIP_CNT_EN
    .skip_count  (skip_count),
`endif
    .cond_pass   (cond_pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] cc,
                       input logic sf, input logic [3:0] rd, input logic [31:0] res,
                       input logic [3:0] fl);
    in_valid   = v;
    op_code    = op;
    conditions = cc;
    s          = sf;
    dest_reg   = rd;
    alu_result = res;
    alu_flags  = fl;
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    #12;
    check("rst_status", 32'(status_nzcv), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
`ifdef ALU_WB_SKIP_CNT_EN
    check("rst_skip", 32'(skip_count), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // ADD AL s=1 R3=0 flags 0100
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 4'd3, 32'h0, 4'b0100);
    #1 check("add_cond_pass", 32'(cond_pass), 32'h1);
    step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0000);
    check("add_status", 32'(status_nzcv), 32'h4);
    check("add_wb_valid", 32'(wb_valid), 32'h1);
    check("add_wb_addr", 32'(wb_addr), 32'h3);
    check("add_wb_data", wb_data, 32'h0);
    wb_ready = 1'b1;
    step();
    check("add_drained", 32'(wb_valid), 32'h0);

    // CMP s=0 flags 0110: flags update, no write
    drive(1'b1, 4'b1011, 4'b0000, 1'b0, 4'd7, 32'hDEAD, 4'b0110);
    step();
    check("cmp_status", 32'(status_nzcv), 32'h6);
    check("cmp_no_write", 32'(wb_valid), 32'h0);
    // SUB EQ s=0 R5=7: passes (Z=1), status kept
    drive(1'b1, 4'b0001, 4'b0001, 1'b0, 4'd5, 32'h7, 4'b1111);
    #1 check("sub_eq_pass", 32'(cond_pass), 32'h1);
    step();
    check("sub_eq_valid", 32'(wb_valid), 32'h1);
    check("sub_eq_addr", 32'(wb_addr), 32'h5);
    check("sub_eq_data", wb_data, 32'h7);
    check("sub_eq_status", 32'(status_nzcv), 32'h6);
    // SUB NE: fails, no write; previous entry drains at the same edge
    drive(1'b1, 4'b0001, 4'b0010, 1'b0, 4'd5, 32'h7, 4'b1111);
    #1 check("sub_ne_fail", 32'(cond_pass), 32'h0);
    step();
    check("sub_ne_no_write", 32'(wb_valid), 32'h0);
    check("sub_ne_status", 32'(status_nzcv), 32'h6);

    // CMP to 0010, then ORR s=1 flags 1111 leaves status alone but writes
    drive(1'b1, 4'b1011, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0010);
    step();
    check("cmp2_status", 32'(status_nzcv), 32'h2);
    drive(1'b1, 4'b0011, 4'b0000, 1'b1, 4'd9, 32'hA5A5, 4'b1111);
    step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0000);
    check("orr_status", 32'(status_nzcv), 32'h2);
    check("orr_valid", 32'(wb_valid), 32'h1);
    check("orr_addr", 32'(wb_addr), 32'h9);
    check("orr_data", wb_data, 32'hA5A5);
    step();
    check("orr_drained", 32'(wb_valid), 32'h0);

    // Condition codes against NZCV=0010
    conditions = 4'b1001; #1 check("cc_hi", 32'(cond_pass), 32'h1);
    conditions = 4'b1010; #1 check("cc_ls", 32'(cond_pass), 32'h0);
    conditions = 4'b1011; #1 check("cc_ge", 32'(cond_pass), 32'h1);
    conditions = 4'b1100; #1 check("cc_lt", 32'(cond_pass), 32'h0);
    conditions = 4'b1101; #1 check("cc_gt", 32'(cond_pass), 32'h1);
    conditions = 4'b0100; #1 check("cc_cc", 32'(cond_pass), 32'h0);
    conditions = 4'b1111; #1 check("cc_nv", 32'(cond_pass), 32'h0);
    step();

    // Backpressure: three writes with wb_ready=0, depth 2
    wb_ready = 1'b0;
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd1, 32'h11, 4'b0000);
    step();
    check("bp1_in_ready", 32'(in_ready), 32'h1);
    check("bp1_addr", 32'(wb_addr), 32'h1);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd2, 32'h22, 4'b0000);
    step();
    check("bp2_full", 32'(in_ready), 32'h0);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd3, 32'h33, 4'b0000);
    step();
    check("bp3_blocked", 32'(in_ready), 32'h0);
    check("bp3_hold_addr", 32'(wb_addr), 32'h1);
    check("bp3_hold_data", wb_data, 32'h11);
    wb_ready = 1'b1;
    step();
    check("pop1_ready", 32'(in_ready), 32'h1);
    check("pop1_addr", 32'(wb_addr), 32'h2);
    check("pop1_data", wb_data, 32'h22);
    step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0000);
    check("pop2_addr", 32'(wb_addr), 32'h3);
    check("pop2_data", wb_data, 32'h33);
    check("pop2_valid", 32'(wb_valid), 32'h1);
    step();
    check("pop3_empty", 32'(wb_valid), 32'h0);

    // Reset mid-drain with two queued entries and status 1001
    wb_ready = 1'b0;
    drive(1'b1, 4'b1011, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b1001);
    step();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd4, 32'h44, 4'b0000);
    step();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'd6, 32'h66, 4'b0000);
    step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0000);
    check("pre_rst_status", 32'(status_nzcv), 32'h9);
    check("pre_rst_full", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", 32'(wb_valid), 32'h0);
    check("arst_status", 32'(status_nzcv), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    check("arst_wb_data", wb_data, 32'h0);
    step();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    step();
    check("post_rst_empty", 32'(wb_valid), 32'h0);

`ifdef ALU_WB_SKIP_CNT_EN
    // Five NV instructions: counted, no writes, status unchanged
    drive(1'b1, 4'b0000, 4'b1111, 1'b1, 4'd8, 32'h88, 4'b1111);
    repeat (5) step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0, 4'b0000);
    check("skip_count", 32'(skip_count), 32'h5);
    check("skip_no_write", 32'(wb_valid), 32'h0);
    check("skip_status", 32'(status_nzcv), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
